ex_mem_stage: RTL
=================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter DATA_W, 32, datapath width.
REQ-002 Parameter REG_ADDR_W, 5, register-file address width.
REQ-003 Parameter SQUASH_SLOTS, 2, wrong-path instructions squashed after a taken BRFL; legal range 1..7.
REQ-004 clock  in  1  single clock; all state SHALL update on its rising edge only.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 stall  in  1  hold all state this cycle.
REQ-007 flush  in  1  kill the incoming instruction and abort squash mode.
REQ-008 valid_in  in  1  EX-stage instruction valid.
REQ-009 alu_result  in  DATA_W  ALU result.
REQ-010 alu_flag  in  3  ALU flag code.
REQ-011 write_data  in  DATA_W  store data.
REQ-012 rd_in  in  REG_ADDR_W  destination register.
REQ-013 reg_write_in, mem_read_in, mem_write_in, flag_write_in, brfl_in  in  1 each  control strobes; brfl_in marks a BRFL instruction.
REQ-014 brfl_cond  in  3  flag code that BRFL tests.
REQ-015 branch_target_in  in  DATA_W  BRFL target address.
REQ-016 valid_out, reg_write_out, mem_read_out, mem_write_out  out  1 each  registered MEM-stage strobes.
REQ-017 alu_result_out, write_data_out, branch_target_out  out  DATA_W  registered data.
REQ-018 rd_out  out  REG_ADDR_W  registered destination.
REQ-019 flag_reg  out  3  architectural flag register.
REQ-020 branch_taken  out  1  one-cycle pulse: BRFL taken, redirect fetch to branch_target_out.
REQ-021 squashing  out  1  high while in SQUASH state.

Function
REQ-022 "Accepted" SHALL mean a rising edge with reset=0, stall=0, flush=0, valid_in=1, state IDLE.
REQ-023 Latency SHALL be one cycle: an accepted instruction's fields appear on the outputs after the next edge, with valid_out=1.
REQ-024 stall=1 (reset=0, flush=0) SHALL hold every output, flag_reg, state and counter unchanged.
REQ-025 flush=1 SHALL override stall: valid_out, all strobes and branch_taken SHALL go 0, data outputs SHALL hold, state SHALL go IDLE, and flag_reg SHALL be unchanged.
REQ-026 valid_in=0 on a non-stall edge SHALL produce a bubble (valid_out and strobes 0, data held).
REQ-027 flag_reg SHALL load alu_flag only for an accepted instruction with flag_write_in=1.
REQ-028 For an accepted instruction with brfl_in=1, branch_taken SHALL be 1 for exactly one cycle iff brfl_cond equals flag_reg's pre-edge value; brfl_in with flag_write_in is illegal and SHALL ignore flag_write_in.
REQ-029 A BRFL SHALL be passed downstream with reg_write_out=0, mem_read_out=0 and mem_write_out=0.
REQ-030 FSM states: IDLE, SQUASH; a taken BRFL SHALL move IDLE->SQUASH and load the counter with SQUASH_SLOTS.
REQ-031 In SQUASH, each non-stall, non-flush edge SHALL output a bubble, write no flag, and decrement the counter only when valid_in=1.
REQ-032 SQUASH SHALL return to IDLE on the edge at which the counter decrements to 0.
REQ-033 The instruction arriving after the last squashed one SHALL be accepted normally.
REQ-034 squashing SHALL equal (state==SQUASH).

Reset
REQ-035 At reset, valid_out, all strobes, branch_taken, squashing, data outputs, rd_out, counter and flag_reg (FLAG_NOT_ACTIVED) SHALL be 0, with state IDLE.
REQ-036 Reset SHALL override flush and stall, and a reset during SQUASH SHALL discard the remaining squash count.

Structure
REQ-037 Package musa_pkg SHALL hold the flag codes: NOT_ACTIVED 000, EQUAL 001, EXCEPTION 010, OVERFLOW 011, UNDERFLOW 100, ABOVE 101.
REQ-038 musa_pkg SHALL also hold the FSM state encoding.
REQ-039 The IDLE/SQUASH FSM and its counter SHALL be a sub-module named branch_squash_ctrl; the pipeline register and flag logic SHALL stay in ex_mem_stage.

Verification
REQ-040 Reset, then one accepted ADD with alu_result=0x00000005, rd_in=3, reg_write_in=1 -> next cycle alu_result_out=5, rd_out=3, valid_out=1, flag_reg=000.
REQ-041 CMP with flag_write_in=1, alu_flag=001, then BRFL with brfl_cond=001 and target 0x40 -> branch_taken pulses 1 cycle, branch_target_out=0x40, the next 2 valid instructions emerge as bubbles, the 3rd emerges valid.
REQ-042 flag_reg=101, then BRFL with brfl_cond=001 -> branch_taken=0, no squash, next instruction valid.
REQ-043 stall=1 for 3 cycles while holding a valid instruction with alu_flag=011, flag_write_in=1 -> outputs and flag_reg frozen; the flag updates to 011 only on the first non-stall edge.
REQ-044 flush=1 and stall=1 together while in SQUASH with count 2 -> valid_out=0, state IDLE, flag_reg unchanged.
REQ-045 reset asserted mid-SQUASH -> all outputs 0, squashing=0, and the next valid instruction is accepted.

Source files
------------

// File: rtl/musa_pkg.sv
// Shared definitions for the EX/MEM pipeline slice: ALU flag codes,
// the branch-squash FSM encoding and the BRFL condition test.
package musa_pkg;

   localparam int FLAG_W       = 3;
   localparam int SQUASH_CNT_W = 3;

   // Flag codes produced by the ALU and tested by BRFL
   typedef enum logic [FLAG_W-1:0] {
      FLAG_NOT_ACTIVED = 3'b000,
      FLAG_EQUAL       = 3'b001,
      FLAG_EXCEPTION   = 3'b010,
      FLAG_OVERFLOW    = 3'b011,
      FLAG_UNDERFLOW   = 3'b100,
      FLAG_ABOVE       = 3'b101
   } flag_e;

   // Branch-squash controller states
   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SQUASH = 1'b1
   } squash_state_e;

   // A BRFL is taken when its condition code matches the current flag register exactly
   function automatic logic brfl_hit(input logic [FLAG_W-1:0] cond,
                                     input logic [FLAG_W-1:0] flags);
      return (cond == flags);
   endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX->MEM boundary bundle. The master side (EX stage / environment) drives
// the instruction fields and pipeline controls; the slave side (the EX/MEM
// register) returns the registered MEM-stage view.
//
// Handshake: there is no ready. valid_in qualifies the EX fields on a rising
// edge; stall=1 freezes the stage (the instruction must be held stable by the
// producer), flush=1 kills the incoming instruction and overrides stall.
// valid_out qualifies the registered fields for exactly the cycles it is high.
interface ex_mem_stage_if #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
);
   import musa_pkg::*;

   // pipeline control
   logic                   stall;
   logic                   flush;
   // EX-stage instruction
   logic                   valid_in;
   logic [DATA_W-1:0]      alu_result;
   logic [FLAG_W-1:0]      alu_flag;
   logic [DATA_W-1:0]      write_data;
   logic [REG_ADDR_W-1:0]  rd_in;
   logic                   reg_write_in;
   logic                   mem_read_in;
   logic                   mem_write_in;
   logic                   flag_write_in;
   logic                   brfl_in;
   logic [FLAG_W-1:0]      brfl_cond;
   logic [DATA_W-1:0]      branch_target_in;
   // registered MEM-stage view
   logic                   valid_out;
   logic                   reg_write_out;
   logic                   mem_read_out;
   logic                   mem_write_out;
   logic [DATA_W-1:0]      alu_result_out;
   logic [DATA_W-1:0]      write_data_out;
   logic [DATA_W-1:0]      branch_target_out;
   logic [REG_ADDR_W-1:0]  rd_out;
   logic [FLAG_W-1:0]      flag_reg;
   logic                   branch_taken;
   logic                   squashing;

   modport master (
      output stall, flush, valid_in, alu_result, alu_flag, write_data, rd_in,
             reg_write_in, mem_read_in, mem_write_in, flag_write_in, brfl_in,
             brfl_cond, branch_target_in,
      input  valid_out, reg_write_out, mem_read_out, mem_write_out,
             alu_result_out, write_data_out, branch_target_out, rd_out,
             flag_reg, branch_taken, squashing
   );

   modport slave (
      input  stall, flush, valid_in, alu_result, alu_flag, write_data, rd_in,
             reg_write_in, mem_read_in, mem_write_in, flag_write_in, brfl_in,
             brfl_cond, branch_target_in,
      output valid_out, reg_write_out, mem_read_out, mem_write_out,
             alu_result_out, write_data_out, branch_target_out, rd_out,
             flag_reg, branch_taken, squashing
   );

endinterface

// File: rtl/ex_mem_stage_branch_squash_ctrl.sv
// IDLE/SQUASH controller: after a taken BRFL, the next SQUASH_SLOTS valid
// instructions are on the wrong path and must be turned into bubbles.
// Invalid cycles during squash do not consume a slot.
module branch_squash_ctrl
   import musa_pkg::*;
#(
   parameter int SQUASH_SLOTS = 2   // legal range 1..7 (fits the 3-bit counter)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    flush,
   input  logic                    valid_in,
   input  logic                    take_branch,
   output squash_state_e           state,
   output logic                    squashing,
   output logic [SQUASH_CNT_W-1:0] count
);

   localparam logic [SQUASH_CNT_W-1:0] SLOTS = SQUASH_CNT_W'(SQUASH_SLOTS);

   // State, remaining-slot counter and registered squashing flag move together
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         count     <= '0;
         squashing <= 1'b0;
      end else if (flush) begin
         // flush aborts any squash in progress, even when stalled
         state     <= ST_IDLE;
         count     <= '0;
         squashing <= 1'b0;
      end else if (!stall) begin
         case (state)
            ST_IDLE: begin
               if (take_branch) begin
                  state     <= ST_SQUASH;
                  count     <= SLOTS;
                  squashing <= 1'b1;
               end
            end
            ST_SQUASH: begin
               if (valid_in) begin
                  count <= count - 1'b1;
                  if (count == SQUASH_CNT_W'(1)) begin
                     state     <= ST_IDLE;
                     squashing <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= ST_IDLE;
               count     <= '0;
               squashing <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with the architectural flag register and BRFL
// resolution. Wrong-path suppression after a taken BRFL is delegated to
// branch_squash_ctrl; this module only accepts instructions while it is IDLE.
module ex_mem_stage
   import musa_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int REG_ADDR_W   = 5,
   parameter int SQUASH_SLOTS = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   ex_mem_stage_if.slave           bus,
   output squash_state_e           fsm_state,
   output logic [SQUASH_CNT_W-1:0] squash_count
);

   logic                  valid_r;
   logic                  reg_write_r;
   logic                  mem_read_r;
   logic                  mem_write_r;
   logic                  branch_taken_r;
   logic [DATA_W-1:0]     alu_result_r;
   logic [DATA_W-1:0]     write_data_r;
   logic [DATA_W-1:0]     branch_target_r;
   logic [REG_ADDR_W-1:0] rd_r;
   logic [FLAG_W-1:0]     flag_r;
   logic                  squashing;
   logic                  accept;
   logic                  take_branch;

   // An instruction is accepted only on a live, unstalled, unflushed IDLE edge
   assign accept      = bus.valid_in && !bus.stall && !bus.flush && (fsm_state == ST_IDLE);
   // Condition is tested against the flag value before this edge's update
   assign take_branch = accept && bus.brfl_in && brfl_hit(bus.brfl_cond, flag_r);

   branch_squash_ctrl #(
      .SQUASH_SLOTS (SQUASH_SLOTS)
   ) u_squash (
      .clock       (clock),
      .reset       (reset),
      .stall       (bus.stall),
      .flush       (bus.flush),
      .valid_in    (bus.valid_in),
      .take_branch (take_branch),
      .state       (fsm_state),
      .squashing   (squashing),
      .count       (squash_count)
   );

   // Pipeline register: load on accept, bubble otherwise, hold on stall, kill on flush
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_r         <= 1'b0;
         reg_write_r     <= 1'b0;
         mem_read_r      <= 1'b0;
         mem_write_r     <= 1'b0;
         branch_taken_r  <= 1'b0;
         alu_result_r    <= '0;
         write_data_r    <= '0;
         branch_target_r <= '0;
         rd_r            <= '0;
      end else if (bus.flush) begin
         // data fields deliberately hold; only qualifiers drop
         valid_r        <= 1'b0;
         reg_write_r    <= 1'b0;
         mem_read_r     <= 1'b0;
         mem_write_r    <= 1'b0;
         branch_taken_r <= 1'b0;
      end else if (!bus.stall) begin
         if (accept) begin
            valid_r         <= 1'b1;
            // a BRFL never writes the register file or memory downstream
            reg_write_r     <= bus.reg_write_in && !bus.brfl_in;
            mem_read_r      <= bus.mem_read_in  && !bus.brfl_in;
            mem_write_r     <= bus.mem_write_in && !bus.brfl_in;
            branch_taken_r  <= take_branch;
            alu_result_r    <= bus.alu_result;
            write_data_r    <= bus.write_data;
            branch_target_r <= bus.branch_target_in;
            rd_r            <= bus.rd_in;
         end else begin
            // bubble: either no instruction or a squashed wrong-path one
            valid_r        <= 1'b0;
            reg_write_r    <= 1'b0;
            mem_read_r     <= 1'b0;
            mem_write_r    <= 1'b0;
            branch_taken_r <= 1'b0;
         end
      end
   end

   // Flag register: written only by an accepted non-BRFL flag-setting instruction
   always_ff @(posedge clock) begin
      if (reset) begin
         flag_r <= FLAG_NOT_ACTIVED;
      end else if (accept && bus.flag_write_in && !bus.brfl_in) begin
         flag_r <= bus.alu_flag;
      end
   end

   assign bus.valid_out         = valid_r;
   assign bus.reg_write_out     = reg_write_r;
   assign bus.mem_read_out      = mem_read_r;
   assign bus.mem_write_out     = mem_write_r;
   assign bus.alu_result_out    = alu_result_r;
   assign bus.write_data_out    = write_data_r;
   assign bus.branch_target_out = branch_target_r;
   assign bus.rd_out            = rd_r;
   assign bus.flag_reg          = flag_r;
   assign bus.branch_taken      = branch_taken_r;
   assign bus.squashing         = squashing;

endmodule
